i2c_master_arbiter: RTL

Shares one I2C master controller between NUM_REQ on-chip requesters. Each requester posts a transaction descriptor: address, address mode, direction and byte count. The arbiter picks one requester by round-robin and drives the master's transaction-begin, address and byte-count configuration. It waits for completion, retries automatically after arbitration loss with a backoff delay, and returns a per-requester done pulse with a status code. It sits between the APB register block / DMA requesters and the master controller's configuration inputs.

---
 rtl/i2c_master_arbiter_pkg.sv | 26 ++
 rtl/i2c_master_arbiter_rr_priority_select.sv | 35 +++
 rtl/i2c_master_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/i2c_master_arbiter_pkg.sv
// rtl/i2c_master_arbiter_pkg.sv - shared types and constants for the I2C master arbiter
package i2c_arbiter_pkg;

  typedef logic [2:0] ArbStateType;

  localparam ArbStateType IDLE      = 3'd0;
  localparam ArbStateType ARBITRATE = 3'd1;
  localparam ArbStateType ISSUE     = 3'd2;
  localparam ArbStateType WAIT_DONE = 3'd3;
  localparam ArbStateType EVALUATE  = 3'd4;
  localparam ArbStateType BACKOFF   = 3'd5;
  localparam ArbStateType REPORT    = 3'd6;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_ACK_ERR  = 2'd1,
    ST_ARB_LOST = 2'd2
  } ArbStatusType;

  // Shared I2C master encodings for address mode and direction
  localparam logic ADDR_7_BIT  = 1'b0;
  localparam logic ADDR_10_BIT = 1'b1;
  localparam logic TX          = 1'b0;
  localparam logic RX          = 1'b1;

endpackage

// File: rtl/i2c_master_arbiter_rr_priority_select.sv
// rtl/i2c_master_arbiter_rr_priority_select.sv - round-robin first-set-bit selector starting at rr_ptr
module rr_priority_select
  import i2c_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx
);

  int                pos;
  logic [IDX_W-1:0]  pos_idx;

  // Scan offsets from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    winner  = '0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = pos[IDX_W-1:0];
      if (req[pos_idx]) begin
        winner          = '0;
        winner[pos_idx] = 1'b1;
        idx             = pos_idx;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin sharing of one I2C master with retry/backoff on arbitration loss
module i2c_master_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*10-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_addr_mode,
  input  logic [NUM_REQ-1:0]    req_dir,
  input  logic [NUM_REQ*8-1:0]  req_byte_count,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [1:0]            status,
  output logic                  begin_transaction,
  output logic [9:0]            bus_address,
  output logic                  address_mode,
  output logic                  data_direction,
  output logic [7:0]            byte_count,
  input  logic                  master_busy,
  input  logic                  bus_busy,
  input  logic                  transaction_complete,
  input  logic                  ack_error,
  input  logic                  arbitration_lost
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int BO_W    = $clog2(BACKOFF_CYCLES + 1);

  ArbStateType          state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     rr_ptr;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [BO_W-1:0]      backoff_cnt;
  logic                 ack_flag;
  logic                 arb_flag;
  logic [NUM_REQ-1:0]   sel_winner;
  logic [IDX_W-1:0]     sel_idx;

  rr_priority_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_select (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (sel_winner),
    .idx    (sel_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      rr_ptr            <= '0;
      retry_cnt         <= '0;
      backoff_cnt       <= '0;
      ack_flag          <= 1'b0;
      arb_flag          <= 1'b0;
      grant             <= '0;
      done              <= '0;
      status            <= ST_OK;
      begin_transaction <= 1'b0;
      bus_address       <= '0;
      address_mode      <= 1'b0;
      data_direction    <= 1'b0;
      byte_count        <= '0;
    end else begin
      begin_transaction <= 1'b0;
      case (state)
        IDLE: if (|req) state <= ARBITRATE;
        ARBITRATE: begin
          if (|req) begin
            idx            <= sel_idx;
            grant          <= sel_winner;
            bus_address    <= req_addr[int'(sel_idx)*10 +: 10];
            address_mode   <= req_addr_mode[sel_idx];
            data_direction <= req_dir[sel_idx];
            byte_count     <= req_byte_count[int'(sel_idx)*8 +: 8];
            state          <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (!master_busy && !bus_busy) begin
            begin_transaction <= 1'b1;
            state             <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          ack_flag <= ack_flag | ack_error;
          arb_flag <= arb_flag | arbitration_lost;
          if (transaction_complete) state <= EVALUATE;
        end
        // done is raised here so it is visible during REPORT while grant still holds
        EVALUATE: begin
          if (arb_flag && (retry_cnt < RETRY_W'(MAX_RETRY))) begin
            retry_cnt   <= retry_cnt + RETRY_W'(1);
            ack_flag    <= 1'b0;
            arb_flag    <= 1'b0;
            backoff_cnt <= BO_W'(BACKOFF_CYCLES);
            state       <= BACKOFF;
          end else begin
            done   <= grant;
            status <= arb_flag ? ST_ARB_LOST : (ack_flag ? ST_ACK_ERR : ST_OK);
            state  <= REPORT;
          end
        end
        BACKOFF: begin
          backoff_cnt <= backoff_cnt - BO_W'(1);
          if (backoff_cnt == BO_W'(1)) state <= ISSUE;
        end
        REPORT: begin
          done      <= '0;
          status    <= ST_OK;
          grant     <= '0;
          rr_ptr    <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
          retry_cnt <= '0;
          ack_flag  <= 1'b0;
          arb_flag  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
